// File: rtl/trigger_latch_controller_if.sv
// Control/status bundle between the trigger sequencer and the latch bank.
// The master drives arming, thresholds and raw strobes; the slave reports FSM status.
interface trigger_latch_controller_if #(
    parameter int N      = 4,
    parameter int CNT_W  = 4,
    parameter int HOLD_W = 16
);
    logic                arm;
    logic                disarm;
    logic                auto_rearm;
    logic [N-1:0]        enable_mask;
    logic [N*CNT_W-1:0]  thresholds;
    logic [HOLD_W-1:0]   holdoff;
    logic [N-1:0]        set_in;

    logic [1:0]          state;
    logic                trigger;
    logic                latched;
    logic [2:0]          first_ch;
    logic [N-1:0]        fired_mask;
    logic [7:0]          missed_count;

    modport master (
        output arm, disarm, auto_rearm, enable_mask, thresholds, holdoff, set_in,
        input  state, trigger, latched, first_ch, fired_mask, missed_count
    );

    modport slave (
        input  arm, disarm, auto_rearm, enable_mask, thresholds, holdoff, set_in,
        output state, trigger, latched, first_ch, fired_mask, missed_count
    );
endinterface

// File: rtl/trigger_latch_controller.sv
// Bank of N counting set/reset latches qualifying discriminator pulses into a
// single trigger, with first-channel resolution, holdoff and optional re-arm.

module trigger_latch_lane #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clr,
    input  logic             count_en,
    input  logic             en_in,
    input  logic [CNT_W-1:0] thr_in,
    input  logic             set,
    output logic             reach,
    output logic             enabled
);
    logic             en_q;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   thr_eff;
    logic             hit;

    // Extra bit keeps cnt+1 from wrapping at the saturation value.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign thr_eff = (thr_q == '0) ? (CNT_W+1)'(1) : {1'b0, thr_q};
    assign hit     = count_en & en_q & set;
    assign reach   = hit & (cnt_inc >= thr_eff);
    assign enabled = en_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q  <= 1'b0;
            thr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load) begin
                en_q  <= en_in;
                thr_q <= thr_in;
            end
            if (clr)
                cnt_q <= '0;
            else if (hit && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

module trigger_latch_controller #(
    parameter int N      = 4,
    parameter int CNT_W  = 4,
    parameter int HOLD_W = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    trigger_latch_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              arm_go, fire, rearm, clr, count_en;
    logic [N-1:0]      reach;
    logic [N-1:0]      en_vec;
    logic [2:0]        first_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              trigger_q, latched_q;
    logic [2:0]        first_q;
    logic [N-1:0]      fired_q;
    logic [7:0]        missed_q;
    logic              in_dead;

    assign count_en = (state_q == ARMED) & ~bus.disarm;
    assign clr      = arm_go | rearm | bus.disarm;
    assign in_dead  = (state_q == TRIGGERED) | (state_q == HOLDOFF);

    for (genvar i = 0; i < N; i++) begin : g_lane
        trigger_latch_lane #(.CNT_W(CNT_W)) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .load     (arm_go),
            .clr      (clr),
            .count_en (count_en),
            .en_in    (bus.enable_mask[i]),
            .thr_in   (bus.thresholds[i*CNT_W +: CNT_W]),
            .set      (bus.set_in[i]),
            .reach    (reach[i]),
            .enabled  (en_vec[i])
        );
    end

    // Fixed priority: lowest reaching channel wins a simultaneous fire.
    always_comb begin
        first_d = '0;
        for (int i = N-1; i >= 0; i--)
            if (reach[i]) first_d = 3'(i);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arm_go  = 1'b0;
        fire    = 1'b0;
        rearm   = 1'b0;
        if (bus.disarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (bus.arm) begin arm_go = 1'b1; state_d = ARMED; end
                ARMED:     if (|reach) begin fire = 1'b1; state_d = TRIGGERED; end
                TRIGGERED: state_d = HOLDOFF;
                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        if (bus.auto_rearm) begin
                            rearm   = 1'b1;
                            state_d = ARMED;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trigger_q <= 1'b0;
            latched_q <= 1'b0;
            first_q   <= '0;
            fired_q   <= '0;
            missed_q  <= '0;
            hold_cnt  <= '0;
        end else begin
            trigger_q <= fire;
            if (arm_go) begin
                latched_q <= 1'b0;
                first_q   <= '0;
                fired_q   <= '0;
            end else if (fire) begin
                latched_q <= 1'b1;
                first_q   <= first_d;
                fired_q   <= reach;
            end else if (rearm || bus.disarm) begin
                latched_q <= 1'b0;
            end

            if (arm_go)
                missed_q <= '0;
            else if (in_dead && |(bus.set_in & en_vec) && missed_q != 8'hFF)
                missed_q <= missed_q + 8'd1;

            if (state_q == TRIGGERED)
                hold_cnt <= bus.holdoff;
            else if (state_q == HOLDOFF && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    assign bus.state        = state_q;
    assign bus.trigger      = trigger_q;
    assign bus.latched      = latched_q;
    assign bus.first_ch     = first_q;
    assign bus.fired_mask   = fired_q;
    assign bus.missed_count = missed_q;
endmodule

// File: tb/tb_trigger_latch_controller.sv
// Directed bench for trigger_latch_controller: arming, thresholds, priority,
// holdoff/re-arm timing, disarm races and saturation boundaries.
module tb_trigger_latch_controller;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   trig_cnt, trig_at;

    trigger_latch_controller_if #(.N(4), .CNT_W(4), .HOLD_W(16)) bus ();

    trigger_latch_controller #(.N(4), .CNT_W(4), .HOLD_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm_with(input logic [15:0] thr, input logic [3:0] mask);
        bus.thresholds  = thr;
        bus.enable_mask = mask;
        bus.arm         = 1'b1;
        tick();
        bus.arm         = 1'b0;
    endtask

    task automatic pulse0();
        bus.set_in = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        tick();
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.arm         = 1'b0;
        bus.disarm      = 1'b0;
        bus.auto_rearm  = 1'b0;
        bus.enable_mask = '0;
        bus.thresholds  = '0;
        bus.holdoff     = '0;
        bus.set_in      = '0;
        #3;
        chk("rst_state",   32'(bus.state), 32'd0);
        chk("rst_trigger", 32'(bus.trigger), 32'd0);
        chk("rst_latched", 32'(bus.latched), 32'd0);
        chk("rst_missed",  32'(bus.missed_count), 32'd0);
        chk("rst_fired",   32'(bus.fired_mask), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick();

        // Three pulses at thr0=3; two are not enough.
        arm_with(16'h0003, 4'b0001);
        chk("arm_state", 32'(bus.state), 32'd1);
        pulse0();
        pulse0();
        chk("two_pulse_state", 32'(bus.state), 32'd1);
        chk("two_pulse_trig",  32'(bus.trigger), 32'd0);
        bus.set_in = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        chk("thr3_trig",    32'(bus.trigger), 32'd1);
        chk("thr3_state",   32'(bus.state), 32'd2);
        chk("thr3_first",   32'(bus.first_ch), 32'd0);
        chk("thr3_fired",   32'(bus.fired_mask), 32'd1);
        chk("thr3_latched", 32'(bus.latched), 32'd1);
        tick();
        chk("thr3_holdoff", 32'(bus.state), 32'd3);
        chk("thr3_trig_off", 32'(bus.trigger), 32'd0);
        tick();
        chk("thr3_idle",     32'(bus.state), 32'd0);
        chk("thr3_keep_lat", 32'(bus.latched), 32'd1);

        // Async reset mid-ARMED with cnt_0=2, then IDLE ignores strobes.
        arm_with(16'h0003, 4'b0001);
        pulse0();
        pulse0();
        chk("pre_rst_state", 32'(bus.state), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_state", 32'(bus.state), 32'd0);
        chk("async_rst_lat",   32'(bus.latched), 32'd0);
        tick();
        reset_n = 1'b1;
        bus.set_in = 4'b1111;
        tick(3);
        bus.set_in = 4'b0000;
        chk("idle_set_state", 32'(bus.state), 32'd0);
        chk("idle_set_trig",  32'(bus.trigger), 32'd0);

        // Simultaneous fire on ch1/ch2; disabled ch0 with thr 1 must not fire.
        arm_with(16'h1221, 4'b0110);
        bus.set_in = 4'b0111;
        tick();
        chk("sim_first_cycle", 32'(bus.trigger), 32'd0);
        tick();
        bus.set_in = 4'b0000;
        chk("sim_trig",  32'(bus.trigger), 32'd1);
        chk("sim_first", 32'(bus.first_ch), 32'd1);
        chk("sim_fired", 32'(bus.fired_mask), 32'd6);
        tick();
        chk("sim_single", 32'(bus.trigger), 32'd0);
        tick();
        chk("sim_idle", 32'(bus.state), 32'd0);

        // Arm while ARMED is ignored: counts and thresholds are not resampled.
        arm_with(16'h0003, 4'b0001);
        pulse0();
        bus.set_in     = 4'b0001;
        bus.arm        = 1'b1;
        bus.thresholds = 16'h000F;
        tick();
        bus.set_in = 4'b0000;
        bus.arm    = 1'b0;
        chk("rearm_ign_state", 32'(bus.state), 32'd1);
        tick();
        bus.set_in = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        chk("rearm_ign_trig", 32'(bus.trigger), 32'd1);
        tick(2);
        chk("rearm_ign_idle", 32'(bus.state), 32'd0);

        // Holdoff=5 with auto re-arm, set_in[0] high through every HOLDOFF cycle.
        bus.holdoff    = 16'd5;
        bus.auto_rearm = 1'b1;
        arm_with(16'h0001, 4'b0001);
        bus.set_in = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        chk("ho_trig", 32'(bus.trigger), 32'd1);
        tick();
        chk("ho_enter", 32'(bus.state), 32'd3);
        bus.set_in = 4'b0001;
        tick(5);
        chk("ho_still", 32'(bus.state), 32'd3);
        tick();
        bus.set_in = 4'b0000;
        chk("ho_rearmed", 32'(bus.state), 32'd1);
        chk("ho_missed",  32'(bus.missed_count), 32'd6);
        chk("ho_lat_clr", 32'(bus.latched), 32'd0);
        chk("ho_no_trig", 32'(bus.trigger), 32'd0);

        // Same arming, auto_rearm=0 -> IDLE with latched kept.
        bus.auto_rearm = 1'b0;
        bus.holdoff    = 16'd0;
        bus.set_in     = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        chk("noar_trig", 32'(bus.trigger), 32'd1);
        tick(2);
        chk("noar_idle",   32'(bus.state), 32'd0);
        chk("noar_lat",    32'(bus.latched), 32'd1);
        chk("noar_missed", 32'(bus.missed_count), 32'd6);

        // Disarm in the same cycle as a qualifying pulse; arm+disarm in IDLE.
        arm_with(16'h0001, 4'b0001);
        bus.set_in = 4'b0001;
        bus.disarm = 1'b1;
        tick();
        bus.set_in = 4'b0000;
        bus.disarm = 1'b0;
        chk("race_state", 32'(bus.state), 32'd0);
        chk("race_trig",  32'(bus.trigger), 32'd0);
        chk("race_lat",   32'(bus.latched), 32'd0);
        bus.arm    = 1'b1;
        bus.disarm = 1'b1;
        tick();
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        chk("armdis_state", 32'(bus.state), 32'd0);

        // Threshold 0 fires on the first pulse.
        arm_with(16'h0000, 4'b0001);
        bus.set_in = 4'b0001;
        tick();
        bus.set_in = 4'b0000;
        chk("thr0_trig", 32'(bus.trigger), 32'd1);
        tick(2);

        // Threshold 15 under 20 continuous pulses fires once, at the 15th.
        arm_with(16'h000F, 4'b0001);
        trig_cnt   = 0;
        trig_at    = 0;
        bus.set_in = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.trigger) begin
                trig_cnt++;
                trig_at = k;
            end
        end
        bus.set_in = 4'b0000;
        chk("thr15_count",  32'(trig_cnt), 32'd1);
        chk("thr15_at",     32'(trig_at), 32'd15);
        chk("thr15_missed", 32'(bus.missed_count), 32'd2);
        chk("thr15_idle",   32'(bus.state), 32'd0);

        // missed_count saturation over 300 dead cycles, retained by disarm.
        bus.holdoff = 16'd400;
        arm_with(16'h0001, 4'b0001);
        bus.set_in = 4'b0001;
        tick();
        chk("sat_trig", 32'(bus.trigger), 32'd1);
        tick(254);
        chk("sat_254", 32'(bus.missed_count), 32'd254);
        tick(46);
        chk("sat_255",   32'(bus.missed_count), 32'd255);
        chk("sat_state", 32'(bus.state), 32'd3);
        bus.set_in = 4'b0000;
        bus.disarm = 1'b1;
        tick();
        bus.disarm = 1'b0;
        chk("sat_dis_state",  32'(bus.state), 32'd0);
        chk("sat_dis_missed", 32'(bus.missed_count), 32'd255);
        chk("sat_dis_lat",    32'(bus.latched), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_latch_controller.md
Name: trigger_latch_controller

Overview:
- Sequences a bank of N counting set/reset latches that qualify repeated event pulses (photon/trigger discriminator outputs) before they are accepted as a trigger.
- Arms all channels together, counts qualifying set pulses per channel against per-channel thresholds, and resolves which channel fired first.
- Issues a one-cycle trigger, holds off for a programmable time, then optionally re-arms.
- Sits between raw discriminator inputs and the pulse-sequencer trigger input.

Parameters:
N, 4, number of latch channels (1..8)
CNT_W, 4, per-channel event counter width; counters saturate at 2^CNT_W-1
HOLD_W, 16, holdoff counter width

Ports:
clock  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset; clears all state immediately
arm  in  1  pulse; IDLE->ARMED, samples thresholds/enable_mask
disarm  in  1  pulse; abort to IDLE from any state; wins over arm
auto_rearm  in  1  level; sampled on leaving HOLDOFF
enable_mask  in  N  per-channel enable, sampled at arm
thresholds  in  N*CNT_W  packed per-channel threshold (ch i at [i*CNT_W +: CNT_W]), sampled at arm
holdoff  in  HOLD_W  holdoff length in clocks, sampled on entering HOLDOFF
set_in  in  N  per-channel event strobes, one event per high cycle
state  out  2  0=IDLE 1=ARMED 2=TRIGGERED 3=HOLDOFF
trigger  out  1  one-cycle pulse on acceptance
latched  out  1  high from trigger until next arm or disarm
first_ch  out  3  index of winning channel, valid while latched
fired_mask  out  N  all channels reaching threshold in the trigger cycle
missed_count  out  8  saturating count of enabled set_in cycles ignored in TRIGGERED/HOLDOFF

Behaviour:
- Reset (async, reset_n=0): state=IDLE; trigger=0, latched=0, first_ch=0, fired_mask=0, missed_count=0; all channel counters=0; sampled thresholds/mask=0. Release is synchronous to clock.
- IDLE:
  - arm=1 and disarm=0: latch enable_mask and thresholds, clear channel counters, missed_count, latched, first_ch and fired_mask; next state=ARMED.
  - set_in is ignored.
- ARMED:
  - Per enabled channel i with set_in[i]=1: cnt_i <= sat(cnt_i+1).
  - Channel i reaches threshold in a cycle when cnt_i+1 >= thr_eff_i, with thr_eff_i = max(thr_i,1). Threshold 0 therefore behaves as 1: the first pulse fires.
  - If any channel reaches threshold, in the same clock edge: fired_mask <= the set of reaching channels; first_ch <= lowest reaching index (fixed priority); trigger <= 1 for exactly one cycle; latched <= 1; next state=TRIGGERED.
  - Disabled channels never count and never fire. A mask of all zeros stays ARMED until disarm.
  - arm while already ARMED is ignored and does not restart counters.
- TRIGGERED: exactly one cycle. Load the holdoff counter with the holdoff input; next state=HOLDOFF.
- HOLDOFF:
  - The counter decrements each cycle. At value 0, leave HOLDOFF.
  - holdoff=0 gives exactly one HOLDOFF cycle. Total trigger-to-ARMED time is therefore holdoff+2 cycles.
  - On exit with auto_rearm=1: clear counters, reuse the stored thresholds/mask, latched <= 0, next state=ARMED.
  - On exit with auto_rearm=0: next state=IDLE; latched, first_ch and fired_mask hold their values.
- Missed events: in TRIGGERED or HOLDOFF, each cycle with (set_in & mask) != 0 increments missed_count by 1, saturating at 255.
- disarm: in any state, next state=IDLE, counters cleared, latched <= 0, trigger forced 0. A trigger that would fire in the same cycle is suppressed. missed_count is retained.
- Channel counters saturate; no wrap. Trigger latency is 1 clock from the qualifying set_in edge to trigger high.

Test Plan:
- Reset/idle: drive reset_n low mid-ARMED with cnt_0=2 -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge; set_in pulses while IDLE -> no trigger, counters remain 0.
- Threshold count: thr0=3, mask=0001, arm, three single-cycle set_in[0] pulses -> trigger on the clock after the 3rd pulse, first_ch=0, fired_mask=0001, latched=1; only 2 pulses -> no trigger.
- Simultaneous fire: thr1=2, thr2=2, mask=0110, set_in=0110 for two cycles -> first_ch=1, fired_mask=0110, single trigger pulse.
- Holdoff/rearm: holdoff=5, auto_rearm=1, set_in[0] held high through holdoff -> state returns to ARMED 7 cycles after the trigger, missed_count=6, latched cleared; auto_rearm=0 -> state=IDLE with latched=1 retained.
- Disarm race: disarm in the same cycle as a qualifying pulse -> no trigger, state=IDLE; arm+disarm together in IDLE -> stays IDLE.
- Edge values: thr=0 fires on the first pulse; thr=15 with 20 pulses fires once, at the 15th pulse; missed_count saturates at 255 after 300 missed cycles.
